// File: rtl/pass_request_ctrl.sv
// Pedestrian/vehicle pass-request controller: debounces a presence sensor and requests green from the light FSM.
// Optional statistics (err flag, grant counter) are enabled by defining PASS_STATS_EN.
module pass_request_ctrl #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned MIN_RED    = 32,
  parameter int unsigned CONFIRM_TO = 16,
  parameter int unsigned COOLDOWN   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       R,
  input  logic       G,
  input  logic       Y,
  output logic       pass,
  output logic       busy,
  output logic       err,
  output logic [7:0] grant_cnt
);

  localparam int unsigned DEB_W   = 8;
  localparam int unsigned TMR_W   = 10;
  localparam int unsigned GRANT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ELIG,
    ST_ISSUE,
    ST_CONFIRM,
    ST_COOLDOWN
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic               sensor_s;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic               deb_q;
  logic               deb_flip_c, deb_rise_c;
  logic [TMR_W-1:0]   red_dwell_q;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               latch_q, latch_clr_c;
  logic               multi_c, green_c, red_short_c, eligible_c, timeout_c;

  // Two-flop synchronizer for the asynchronous contact
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], sensor};
  end
  assign sensor_s = sync_q[1];

  // Level flips after DEB_CYCLES consecutive differing samples; any matching sample restarts the count
  assign deb_flip_c = (sensor_s != deb_q) && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
  assign deb_rise_c = deb_flip_c && sensor_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else if (sensor_s == deb_q) begin
      deb_cnt_q <= '0;
    end else if (deb_flip_c) begin
      deb_q     <= sensor_s;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  // Red dwell: saturating count of consecutive R-high cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   red_dwell_q <= '0;
    else if (!R)                red_dwell_q <= '0;
    else if (red_dwell_q != '1) red_dwell_q <= red_dwell_q + TMR_W'(1);
  end

  // Illegal light combinations count as neither green nor eligible
  assign multi_c     = (R & G) | (R & Y) | (G & Y);
  assign green_c     = G & ~multi_c;
  assign red_short_c = R && (red_dwell_q < TMR_W'(MIN_RED));
  assign eligible_c  = ~multi_c & ~G & ~red_short_c;
  // A G rise in the last confirm cycle wins over the timeout
  assign timeout_c   = (state_q == ST_CONFIRM) && !green_c &&
                       (tmr_q == TMR_W'(CONFIRM_TO - 1));

  // Single-entry request latch; a new edge coinciding with a clear is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) latch_q <= 1'b0;
    else      latch_q <= deb_rise_c | (latch_q & ~latch_clr_c);
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = '0;
    latch_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (latch_q) state_d = ST_WAIT_ELIG;
      end
      ST_WAIT_ELIG: begin
        if (green_c) begin
          latch_clr_c = 1'b1;
          state_d     = ST_IDLE;
        end else if (eligible_c) begin
          latch_clr_c = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (green_c || timeout_c) state_d = ST_COOLDOWN;
        else                      tmr_d   = tmr_q + TMR_W'(1);
      end
      ST_COOLDOWN: begin
        if (tmr_q == TMR_W'(COOLDOWN - 1)) state_d = ST_IDLE;
        else                                tmr_d   = tmr_q + TMR_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // pass/busy are registered copies of the next state, so they track the state exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      pass    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pass    <= (state_d == ST_ISSUE);
      busy    <= (state_d != ST_IDLE);
    end
  end

`ifdef PASS_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err       <= 1'b0;
      grant_cnt <= '0;
    end else begin
      if (timeout_c) err <= 1'b1;
      if ((state_d == ST_ISSUE) && (grant_cnt != '1)) grant_cnt <= grant_cnt + GRANT_W'(1);
    end
  end
`else
  assign err       = 1'b0;
  assign grant_cnt = '0;
`endif

endmodule

// File: doc/pass_request_ctrl.md
PASS_REQUEST_CTRL -- requirements
Module: pass_request_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive equal synchronized sensor samples required to change the debounced level (1..255).
REQ-002 Parameter MIN_RED, default 32: minimum cycles R must be continuously high before pass may be issued during red (0..1023).
REQ-003 Parameter CONFIRM_TO, default 16: cycles allowed after pass for G to rise (1..1023).
REQ-004 Parameter COOLDOWN, default 64: cycles after each service before a new pass may be issued (1..1023).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 sensor  input  1  raw, asynchronous vehicle-presence contact.
REQ-008 R, G, Y  input  1 each  light outputs of the traffic light controller, synchronous to clk.
REQ-009 pass  output  1  registered one-cycle pulse requesting return to green.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 err  output  1  sticky flag: G failed to rise within CONFIRM_TO.
REQ-012 grant_cnt  output  8  number of pass pulses issued, saturating at 255.

Function
REQ-013 sensor shall pass through a 2-flop synchronizer; the debounced level shall change only after DEB_CYCLES consecutive synchronized samples differ from it; any matching sample clears the debounce counter.
REQ-014 A 0->1 transition of the debounced level shall set the request latch; the latch is cleared only on entry to ISSUE or by the G-drop rule (REQ-017).
REQ-015 A red-dwell counter shall count cycles with R=1, saturate at 1023, and clear in any cycle with R=0.
REQ-016 FSM states: IDLE, WAIT_ELIG, ISSUE, CONFIRM, COOLDOWN; IDLE -> WAIT_ELIG when the latch is set.
REQ-017 WAIT_ELIG: if G=1, clear the latch and return to IDLE without issuing pass; else, if eligible (G=0 and not (R=1 and red-dwell < MIN_RED)), go to ISSUE; otherwise stay.
REQ-018 ISSUE: pass=1 for exactly this one cycle, latch cleared, grant_cnt incremented (saturating), next state CONFIRM.
REQ-019 CONFIRM: a timer counts from 0; G=1 -> COOLDOWN; if the timer reaches CONFIRM_TO with G=0, set err and go to COOLDOWN.
REQ-020 COOLDOWN: stay exactly COOLDOWN cycles, then IDLE; debounced edges during COOLDOWN still set the latch, so a pending request is served from IDLE on the following cycle.
REQ-021 Simultaneous G rise and timeout in CONFIRM: G wins, err unchanged.
REQ-022 A new debounced edge while the latch is already set shall have no additional effect (no queuing beyond one).
REQ-023 pass shall never be high in two consecutive cycles nor outside ISSUE.
REQ-024 Inputs R/G/Y with more than one bit high shall be treated as not eligible and as not green.

Reset
REQ-025 rst low shall immediately force: FSM IDLE, pass=0, busy=0, err=0, grant_cnt=0, latch=0, debounced level=0, synchronizer flops=0, all counters=0.
REQ-026 Reset asserted mid-operation (any state, including during a pass pulse) shall abort the operation with no further pass; after release, operation restarts from IDLE.

Configuration
REQ-027 Macro PASS_STATS_EN: when defined, grant_cnt counts per REQ-018 and err is sticky per REQ-019; when undefined, grant_cnt shall be constant 0, err constant 0, and the timeout path shall still transition CONFIRM -> COOLDOWN.

Verification (defaults: DEB_CYCLES=4, MIN_RED=32, CONFIRM_TO=16, COOLDOWN=64)
REQ-028 Sensor glitches high for 3 cycles, R=1 held -> no latch set, pass never asserted, busy stays 0.
REQ-029 Sensor high for 10 cycles, Y=1 held -> one pass pulse, 7-8 cycles after sensor rise (2-flop sync + 4 debounce + FSM); G driven high 3 cycles later -> COOLDOWN for 64 cycles, then busy=0; grant_cnt=1.
REQ-030 R rises at cycle 0, debounced request at cycle 5 -> pass asserted no earlier than the cycle where red-dwell reaches 32.
REQ-031 Request while G=1 -> FSM returns to IDLE, no pass, latch cleared, grant_cnt unchanged.
REQ-032 After pass, G held 0 -> err=1 after 16 cycles, stays 1 through COOLDOWN and IDLE until rst; second request issued during COOLDOWN served immediately after COOLDOWN ends.
REQ-033 rst pulsed low in CONFIRM and again in the ISSUE cycle -> outputs zero asynchronously, no pass on release, grant_cnt=0.
